regfile_wb_arbiter: RTL and testbench

- Shares the single write port of the 2-read/1-write register file among `NUM_REQ` writeback sources, such as the ALU, load unit and multiplier.
- Arbitration is round-robin with one grant per cycle and a valid/ready handshake per requester.
- The granted write goes into a registered output stage that drives the register file's `wr_en`/`wr_addr`/`wr_data` directly.
- Pending-write visibility is exported so decode logic can forward or stall.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_wb_arbiter_if.sv | 34 +++
 rtl/rr_priority_picker.sv | 30 +++
 rtl/regfile_wb_arbiter.sv | 94 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Constants shared by the register file and its writeback arbiter.
package regfile_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 4;
    localparam int unsigned RF_ZERO_ADDR       = 0;
    localparam int unsigned MAX_NUM_REQ        = 8;

    function automatic bit num_req_ok(input int unsigned n);
        return (n >= 2) && (n <= MAX_NUM_REQ);
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus plus the register-file write port driven by the arbiter.
interface regfile_wb_arbiter_if
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned NUM_REQ    = 3
) ();

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic                          hold;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic                          wr_en;
    logic [ADDR_WIDTH-1:0]         wr_addr;
    logic [DATA_WIDTH-1:0]         wr_data;
    logic                          pend_valid;
    logic [ADDR_WIDTH-1:0]         pend_addr;
    logic [IDX_W-1:0]              grant_id;

    modport master (
        output hold, req_valid, req_addr, req_data,
        input  req_ready, wr_en, wr_addr, wr_data, pend_valid, pend_addr, grant_id
    );

    modport slave (
        input  hold, req_valid, req_addr, req_data,
        output req_ready, wr_en, wr_addr, wr_data, pend_valid, pend_addr, grant_id
    );

endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request after index `last`, wrapping.
module rr_priority_picker #(
    parameter int unsigned NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((32'(last) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
        gnt = found ? (NUM_REQ'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among writeback sources,
// with a one-cycle registered write stage that also exports the pending write.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned NUM_REQ    = 3
) (
    input logic                 clk,
    input logic                 rst_n,
    regfile_wb_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    pick_req;
    logic [NUM_REQ-1:0]    gnt;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  xfer;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    logic [IDX_W-1:0]      last_q, last_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [IDX_W-1:0]      gid_q, gid_d;

    // Masking the picker input keeps ready low during hold and reset.
    assign pick_req = (rst_n && !bus.hold) ? bus.req_valid : '0;

    rr_priority_picker #(
        .NUM_REQ(NUM_REQ)
    ) u_picker (
        .req    (pick_req),
        .last   (last_q),
        .gnt    (gnt),
        .gnt_idx(gnt_idx)
    );

    assign bus.req_ready = gnt;
    assign xfer          = |gnt;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_addr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        last_d    = last_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        gid_d     = gid_q;
        if (xfer) begin
            last_d    = gnt_idx;
            wr_en_d   = (sel_addr != ADDR_WIDTH'(RF_ZERO_ADDR));
            wr_addr_d = sel_addr;
            wr_data_d = sel_data;
            gid_d     = gnt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q    <= IDX_W'(NUM_REQ - 1);
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            gid_q     <= '0;
        end else begin
            last_q    <= last_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            gid_q     <= gid_d;
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.pend_valid = wr_en_q;
    assign bus.pend_addr  = wr_addr_q;
    assign bus.grant_id   = gid_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios on a 3-requester instance,
// randomized runs against a behavioural model, and a soak on a 4-requester instance.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        trst;
    logic        th;
    logic [7:0]  tv;
    logic [3:0]  ta [8];
    logic [31:0] td [8];
    bit          sel4;
    bit          chk_obl;

    int n_checks;
    int n_errors;

    logic [7:0]  o_ready;
    logic        o_en, o_pv;
    logic [3:0]  o_addr, o_pa;
    logic [31:0] o_data;
    logic [2:0]  o_gid;

    // Reference model state
    int          m_last;
    logic        m_en;
    logic [3:0]  m_addr;
    logic [31:0] m_data;
    logic [2:0]  m_gid;
    logic [31:0] m_rf [16] = '{default: 32'h0};
    logic [31:0] rf   [16] = '{default: 32'h0};

    regfile_wb_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_REQ(3)) if3 ();
    regfile_wb_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_REQ(4)) if4 ();

    regfile_wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_REQ(3)) u_dut3 (
        .clk(clk), .rst_n(trst), .bus(if3.slave));
    regfile_wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_REQ(4)) u_dut4 (
        .clk(clk), .rst_n(trst), .bus(if4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        if3.hold      = th && !sel4;
        if3.req_valid = sel4 ? 3'b000 : tv[2:0];
        if3.req_addr  = '0;
        if3.req_data  = '0;
        for (int i = 0; i < 3; i++) begin
            if3.req_addr[i*4 +: 4]   = ta[i];
            if3.req_data[i*32 +: 32] = td[i];
        end
        if4.hold      = th && sel4;
        if4.req_valid = sel4 ? tv[3:0] : 4'b0000;
        if4.req_addr  = '0;
        if4.req_data  = '0;
        for (int i = 0; i < 4; i++) begin
            if4.req_addr[i*4 +: 4]   = ta[i];
            if4.req_data[i*32 +: 32] = td[i];
        end
    end

    always_comb begin
        if (sel4) begin
            o_ready = {4'b0, if4.req_ready};
            o_en = if4.wr_en; o_addr = if4.wr_addr; o_data = if4.wr_data;
            o_gid = {1'b0, if4.grant_id}; o_pv = if4.pend_valid; o_pa = if4.pend_addr;
        end else begin
            o_ready = {5'b0, if3.req_ready};
            o_en = if3.wr_en; o_addr = if3.wr_addr; o_data = if3.wr_data;
            o_gid = {1'b0, if3.grant_id}; o_pv = if3.pend_valid; o_pa = if3.pend_addr;
        end
    end

    // Register file written by whichever arbiter is active
    always @(posedge clk) begin
        if (o_en) rf[o_addr] <= o_data;
    end

    for (genvar i = 0; i < 3; i++) begin : g_obl3
        a_obl: assert property (@(posedge clk) disable iff (!chk_obl)
            (if3.req_valid[i] && !if3.req_ready[i]) |=>
            (if3.req_valid[i] && $stable(if3.req_addr[i*4 +: 4]) && $stable(if3.req_data[i*32 +: 32])))
            else $error("requester %0d (3-way) dropped or changed an ungranted request", i);
    end
    for (genvar i = 0; i < 4; i++) begin : g_obl4
        a_obl: assert property (@(posedge clk) disable iff (!chk_obl)
            (if4.req_valid[i] && !if4.req_ready[i]) |=>
            (if4.req_valid[i] && $stable(if4.req_addr[i*4 +: 4]) && $stable(if4.req_data[i*32 +: 32])))
            else $error("requester %0d (4-way) dropped or changed an ungranted request", i);
    end

    // Winner = lowest set bit of the valid vector rotated so that last+1 sits at bit 0.
    function automatic int pick(input logic [7:0] v, input int last, input int n);
        logic [15:0] vm, rot;
        int start;
        start = (last + 1) % n;
        vm    = {8'h00, v} & ((16'd1 << n) - 16'd1);
        rot   = (vm | (vm << n)) >> start;
        for (int p = 0; p < n; p++) begin
            if (rot[p]) return (start + p) % n;
        end
        return -1;
    endfunction

    function automatic logic [7:0] exp_ready(input int n);
        int g;
        g = pick(tv, m_last, n);
        return (trst && !th && g >= 0) ? 8'(1 << g) : 8'h00;
    endfunction

    // Advance one clock, applying the behavioural rules to the model at the edge.
    task automatic tick();
        int n, g;
        n = sel4 ? 4 : 3;
        g = pick(tv, m_last, n);
        @(posedge clk);
        if (m_en) m_rf[m_addr] = m_data;
        if (!trst) begin
            m_en = 1'b0; m_addr = '0; m_data = '0; m_gid = '0; m_last = n - 1;
        end else if (!th && g >= 0) begin
            m_en = (ta[g] != 4'd0); m_addr = ta[g]; m_data = td[g]; m_gid = 3'(g); m_last = g;
        end else begin
            m_en = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        trst = 1'b0; th = 1'b0; tv = 8'b111;
        for (int i = 0; i < 3; i++) begin ta[i] = 4'(i + 2); td[i] = $urandom; end
        #1;
        n_checks++;
        if (o_ready !== 8'h00) begin
            n_errors++; $display("FAIL reset_ready: req_ready=%b expected 0", o_ready);
        end
        tick(); tick();
        n_checks++;
        if ({o_en, o_addr, o_data, o_gid, o_pv} !== 41'h0) begin
            n_errors++;
            $display("FAIL reset_state: en=%b addr=%h data=%h gid=%0d pv=%b expected all zero",
                     o_en, o_addr, o_data, o_gid, o_pv);
        end
    endtask

    task automatic test_single();
        trst = 1'b1; tv = 8'b010; ta[1] = 4'd5; td[1] = 32'hDEADBEEF;
        #1;
        n_checks++;
        if (o_ready !== 8'b010) begin
            n_errors++; $display("FAIL single_ready: req_ready=%b expected 010", o_ready);
        end
        tick();
        tv = 8'h00;
        n_checks++;
        if ({o_en, o_addr, o_data, o_gid, o_pv, o_pa} !== {1'b1, 4'd5, 32'hDEADBEEF, 3'd1, 1'b1, 4'd5}) begin
            n_errors++;
            $display("FAIL single_write: en=%b addr=%0d data=%h gid=%0d pv=%b pa=%0d expected 1 5 deadbeef 1 1 5",
                     o_en, o_addr, o_data, o_gid, o_pv, o_pa);
        end
    endtask

    task automatic test_rotation();
        logic [31:0] exp_d;
        int          g;
        trst = 1'b0; tv = 8'h00; tick(); trst = 1'b1;
        for (int i = 0; i < 3; i++) begin ta[i] = 4'(i + 1); td[i] = $urandom; end
        tv = 8'b111;
        for (int k = 0; k < 6; k++) begin
            g = k % 3;
            #1;
            n_checks++;
            if (o_ready !== 8'(1 << g)) begin
                n_errors++; $display("FAIL rotation_ready[%0d]: req_ready=%b expected requester %0d", k, o_ready, g);
            end
            exp_d = td[g];
            tick();
            td[g] = $urandom;
            n_checks++;
            if ({o_en, o_gid, o_addr, o_data} !== {1'b1, 3'(g), 4'(g + 1), exp_d}) begin
                n_errors++;
                $display("FAIL rotation_write[%0d]: en=%b gid=%0d addr=%0d data=%h expected 1 %0d %0d %h",
                         k, o_en, o_gid, o_addr, o_data, g, g + 1, exp_d);
            end
        end
        tv = 8'h00;
    endtask

    task automatic test_r0();
        tv = 8'b100; ta[2] = 4'd0; td[2] = 32'h1234;
        #1;
        n_checks++;
        if (o_ready !== 8'b100) begin
            n_errors++; $display("FAIL r0_ready: req_ready=%b expected 100", o_ready);
        end
        tick();
        tv = 8'h00;
        n_checks++;
        if ({o_en, o_pv, o_gid, o_addr, o_data} !== {1'b0, 1'b0, 3'd2, 4'd0, 32'h1234}) begin
            n_errors++;
            $display("FAIL r0_write: en=%b pv=%b gid=%0d addr=%0d data=%h expected 0 0 2 0 1234",
                     o_en, o_pv, o_gid, o_addr, o_data);
        end
        tick();
        n_checks++;
        if (rf[0] !== 32'h0) begin
            n_errors++; $display("FAIL r0_read: rf[0]=%h expected 0", rf[0]);
        end
    endtask

    task automatic test_hold();
        tv = 8'b011; ta[0] = 4'd3; ta[1] = 4'd7; td[0] = $urandom; td[1] = $urandom;
        #1;
        n_checks++;
        if (o_ready !== 8'b001) begin
            n_errors++; $display("FAIL hold_pre_ready: req_ready=%b expected 001", o_ready);
        end
        tick();
        n_checks++;
        if ({o_en, o_gid} !== {1'b1, 3'd0}) begin
            n_errors++; $display("FAIL hold_pre_write: en=%b gid=%0d expected 1 0", o_en, o_gid);
        end
        th = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (o_ready !== 8'h00) begin
                n_errors++; $display("FAIL hold_ready[%0d]: req_ready=%b expected 0", k, o_ready);
            end
            tick();
            n_checks++;
            if (o_en !== 1'b0) begin
                n_errors++; $display("FAIL hold_drain[%0d]: wr_en=%b expected 0", k, o_en);
            end
        end
        th = 1'b0;
        #1;
        n_checks++;
        if (o_ready !== 8'b010) begin
            n_errors++; $display("FAIL hold_release: req_ready=%b expected 010", o_ready);
        end
        tick();
        n_checks++;
        if ({o_en, o_gid, o_addr} !== {1'b1, 3'd1, 4'd7}) begin
            n_errors++; $display("FAIL hold_release_write: en=%b gid=%0d addr=%0d expected 1 1 7", o_en, o_gid, o_addr);
        end
    endtask

    task automatic test_reset_mid();
        tv = 8'b100; ta[2] = 4'd9; td[2] = $urandom;
        #1;
        n_checks++;
        if (o_ready !== 8'b100) begin
            n_errors++; $display("FAIL midrst_ready_n: req_ready=%b expected 100", o_ready);
        end
        tick();
        trst = 1'b0; tv = 8'b111;
        #1;
        n_checks++;
        if ({o_en, o_ready} !== {1'b1, 8'h00}) begin
            n_errors++; $display("FAIL midrst_n1: wr_en=%b req_ready=%b expected 1 0", o_en, o_ready);
        end
        tick();
        trst = 1'b1;
        #1;
        n_checks++;
        if ({o_en, o_ready} !== {1'b0, 8'b001}) begin
            n_errors++; $display("FAIL midrst_n2: wr_en=%b req_ready=%b expected 0 001", o_en, o_ready);
        end
        tick();
        tv = 8'h00;
        n_checks++;
        if ({o_en, o_gid} !== {1'b1, 3'd0}) begin
            n_errors++; $display("FAIL midrst_first_grant: en=%b gid=%0d expected 1 0", o_en, o_gid);
        end
    endtask

    task automatic run_random(input int cycles, input int hold_pct, input int rst_pm, input string tag);
        int         n;
        logic [7:0] er, seen;
        int         wait_c [8];
        n = sel4 ? 4 : 3;
        tv = 8'h00; th = 1'b0; trst = 1'b1;
        tick();
        chk_obl = 1'b1;
        for (int i = 0; i < 8; i++) wait_c[i] = 0;
        for (int c = 0; c < cycles; c++) begin
            for (int i = 0; i < n; i++) begin
                if (!tv[i] && $urandom_range(1, 0) == 1) begin
                    tv[i] = 1'b1; ta[i] = 4'($urandom); td[i] = $urandom;
                end
            end
            th   = ($urandom_range(99, 0) < hold_pct);
            trst = !($urandom_range(999, 0) < rst_pm);
            #1;
            er   = exp_ready(n);
            seen = o_ready;
            n_checks++;
            if (seen !== er) begin
                n_errors++;
                $display("FAIL %s_grant c%0d: req_ready=%b expected %b (valid=%b hold=%b rst_n=%b)",
                         tag, c, seen, er, tv, th, trst);
            end
            n_checks++;
            if ($countones(seen) !== ((tv != 8'h00 && !th && trst) ? 1 : 0)) begin
                n_errors++; $display("FAIL %s_onegrant c%0d: req_ready=%b valid=%b hold=%b", tag, c, seen, tv, th);
            end
            for (int i = 0; i < n; i++) begin
                if (!trst) wait_c[i] = 0;
                else if (seen[i]) begin
                    n_checks++;
                    if (wait_c[i] > n - 1) begin
                        n_errors++; $display("FAIL %s_fair c%0d: requester %0d waited %0d cycles, limit %0d",
                                             tag, c, i, wait_c[i], n - 1);
                    end
                    wait_c[i] = 0;
                end else if (tv[i] && !th) wait_c[i]++;
            end
            tick();
            n_checks++;
            if ({o_en, o_addr, o_data, o_gid, o_pv, o_pa} !== {m_en, m_addr, m_data, m_gid, m_en, m_addr}) begin
                n_errors++;
                $display("FAIL %s_stage c%0d: en=%b addr=%h data=%h gid=%0d pv=%b pa=%h expected en=%b addr=%h data=%h gid=%0d",
                         tag, c, o_en, o_addr, o_data, o_gid, o_pv, o_pa, m_en, m_addr, m_data, m_gid);
            end
            for (int i = 0; i < n; i++) if (seen[i]) tv[i] = 1'b0;
        end
        chk_obl = 1'b0;
        tv = 8'h00; th = 1'b0; trst = 1'b1;
        tick();
    endtask

    task automatic test_random3();
        sel4 = 1'b0;
        run_random(400, 20, 20, "rand3");
    endtask

    task automatic test_soak4();
        trst = 1'b0; tv = 8'h00; sel4 = 1'b1;
        tick();
        trst = 1'b1;
        run_random(10000, 10, 0, "soak4");
        for (int r = 0; r < 16; r++) begin
            n_checks++;
            if (rf[r] !== m_rf[r]) begin
                n_errors++; $display("FAIL soak_rf[%0d]: got %h expected %h", r, rf[r], m_rf[r]);
            end
        end
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        sel4 = 1'b0; chk_obl = 1'b0;
        trst = 1'b0; th = 1'b0; tv = 8'h00;
        for (int i = 0; i < 8; i++) begin ta[i] = '0; td[i] = '0; end
        m_last = 2; m_en = 1'b0; m_addr = '0; m_data = '0; m_gid = '0;
        test_reset();
        test_single();
        test_rotation();
        test_r0();
        test_hold();
        test_reset_mid();
        test_random3();
        test_soak4();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
